// File: rtl/im_mem_pkg.sv
// im_mem_pkg: access sizes, controller states and byte-lane helpers for the IM data-memory stage
package im_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
        return sz == SZ_BYTE ? 4'b1000 >> off : sz == SZ_HALF ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    endfunction
    function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
        return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
    endfunction
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return sz == SZ_HALF ? off[0] : sz != SZ_BYTE && off != 2'b00;
    endfunction
endpackage

// File: rtl/im_dmem_access_ctrl_if.sv
// im_dmem_access_ctrl_if: ready/valid data-memory port
//   master: req, we, addr, be, wdata out; ready, rvalid, rdata in
//   slave : the mirror image
interface im_dmem_access_ctrl_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master(output req, we, addr, be, wdata, input ready, rvalid, rdata);
    modport slave(input req, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/im_load_aligner.sv
// im_load_aligner: selects the big-endian byte/half lane of a read word and sign/zero-extends it
//   rdata in 32, off in 2, sz in 2, sx in 1, result out 32
module im_load_aligner
    import im_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  sz,
    input  logic        sx,
    output logic [31:0] result
);
    logic [31:0] sh;
    logic [15:0] h;
    // shifting the addressed byte into the top lane makes offset 0 = bits 31:24
    assign sh = rdata << {off, 3'b000};
    assign h = off[1] ? rdata[15:0] : rdata[31:16];
    assign result = sz == SZ_BYTE ? {{24{sx & sh[31]}}, sh[31:24]} :
                    sz == SZ_HALF ? {{16{sx & h[15]}}, h} : rdata;
endmodule

// File: rtl/im_dmem_access_ctrl.sv
// im_dmem_access_ctrl: IM-stage data-memory access FSM with pipeline stall and load alignment
//   clk, rst (sync, active high)
//   mem_access_in, addr_in, store_data_in, access_size_in, rw_in, sign_extend_in: IX/IM request fields
//   dmem (master): ready/valid data-memory port
//   stall, load_data_out, load_valid_out, misalign_err: pipeline-facing results
//   MISALIGN_TRAP_EN: misaligned half/word accesses trap to DONE with misalign_err instead of accessing memory
module im_dmem_access_ctrl
    import im_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_access_in,
    input  logic [ADDR_W-1:0]      addr_in,
    input  logic [31:0]            store_data_in,
    input  logic [1:0]             access_size_in,
    input  logic                   rw_in,
    input  logic                   sign_extend_in,
    im_dmem_access_ctrl_if.master  dmem,
    output logic                   stall,
    output logic [31:0]            load_data_out,
    output logic                   load_valid_out,
    output logic                   misalign_err
);
    state_t      state;
    logic [1:0]  a_off;
    logic [1:0]  a_sz;
    logic        a_rw;
    logic        a_sx;
    logic        mis;
    logic [31:0] aligned;
`ifdef MISALIGN_TRAP_EN
    assign mis = misaligned(access_size_in, addr_in[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign stall = (state == IDLE && mem_access_in) || state == REQ || state == WAIT;
    im_load_aligner u_align (
        .rdata  (dmem.rdata),
        .off    (a_off),
        .sz     (a_sz),
        .sx     (a_sx),
        .result (aligned)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            a_off          <= 2'b00;
            a_sz           <= SZ_BYTE;
            a_rw           <= 1'b0;
            a_sx           <= 1'b0;
            dmem.req       <= 1'b0;
            dmem.we        <= 1'b0;
            dmem.addr      <= '0;
            dmem.be        <= 4'b0000;
            dmem.wdata     <= 32'h0;
            load_data_out  <= 32'h0;
            load_valid_out <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misalign_err   <= 1'b0;
            case (state)
                IDLE: if (mem_access_in) begin
                    a_off <= addr_in[1:0];
                    a_sz  <= access_size_in;
                    a_rw  <= rw_in;
                    a_sx  <= sign_extend_in;
                    if (mis) begin
                        misalign_err <= 1'b1;
                        state        <= DONE;
                    end else begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= rw_in;
                        dmem.addr  <= {addr_in[ADDR_W-1:2], 2'b00};
                        dmem.be    <= be_of(access_size_in, addr_in[1:0]);
                        dmem.wdata <= wdata_of(access_size_in, store_data_in);
                        state      <= REQ;
                    end
                end
                REQ: if (dmem.ready) begin
                    dmem.req <= 1'b0;
                    dmem.we  <= 1'b0;
                    state    <= a_rw ? DONE : WAIT;
                end
                WAIT: if (dmem.rvalid) begin
                    load_data_out  <= aligned;
                    load_valid_out <= 1'b1;
                    state          <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im_dmem_access_ctrl.sv
// tb_im_dmem_access_ctrl: directed self-checking bench for the IM data-memory access controller
module tb_im_dmem_access_ctrl;
    import im_mem_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_access_in = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] store_data_in = 32'h0;
    logic [1:0]  access_size_in = 2'b00;
    logic        rw_in = 1'b0;
    logic        sign_extend_in = 1'b0;
    logic        stall;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        misalign_err;
    int checks = 0;
    int errors = 0;
    im_dmem_access_ctrl_if bus ();
    im_dmem_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_access_in  (mem_access_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .access_size_in (access_size_in),
        .rw_in          (rw_in),
        .sign_extend_in (sign_extend_in),
        .dmem           (bus),
        .stall          (stall),
        .load_data_out  (load_data_out),
        .load_valid_out (load_valid_out),
        .misalign_err   (misalign_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] ea,
                            input int hold, input string tag);
        mem_access_in = 1'b1;
        addr_in = a;
        access_size_in = sz;
        store_data_in = d;
        rw_in = 1'b1;
        #1 chk({tag, " idle stall"}, 32'(stall), 1);
        tick();
        for (int i = 0; i <= hold; i++) begin
            chk({tag, " req"}, 32'(bus.req), 1);
            chk({tag, " we"}, 32'(bus.we), 1);
            chk({tag, " be"}, 32'(bus.be), 32'(ebe));
            chk({tag, " wdata"}, bus.wdata, ewd);
            chk({tag, " addr"}, bus.addr, ea);
            chk({tag, " req stall"}, 32'(stall), 1);
            if (i == hold) bus.ready = 1'b1;
            tick();
        end
        bus.ready = 1'b0;
        chk({tag, " done req"}, 32'(bus.req), 0);
        chk({tag, " done stall"}, 32'(stall), 0);
        chk({tag, " done lv"}, 32'(load_valid_out), 0);
        mem_access_in = 1'b0;
        tick();
        chk({tag, " idle req"}, 32'(bus.req), 0);
        chk({tag, " idle lv"}, 32'(load_valid_out), 0);
    endtask
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx, input logic [31:0] rd,
                           input int lat, input logic [3:0] ebe, input logic [31:0] ea,
                           input logic [31:0] ed, input string tag);
        mem_access_in = 1'b1;
        addr_in = a;
        access_size_in = sz;
        sign_extend_in = sx;
        rw_in = 1'b0;
        #1 chk({tag, " idle stall"}, 32'(stall), 1);
        tick();
        chk({tag, " req"}, 32'(bus.req), 1);
        chk({tag, " we"}, 32'(bus.we), 0);
        chk({tag, " be"}, 32'(bus.be), 32'(ebe));
        chk({tag, " addr"}, bus.addr, ea);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        chk({tag, " wait req"}, 32'(bus.req), 0);
        chk({tag, " wait stall"}, 32'(stall), 1);
        repeat (lat - 1) begin
            tick();
            chk({tag, " wait lv"}, 32'(load_valid_out), 0);
            chk({tag, " wait stall"}, 32'(stall), 1);
        end
        bus.rvalid = 1'b1;
        bus.rdata = rd;
        tick();
        bus.rvalid = 1'b0;
        chk({tag, " data"}, load_data_out, ed);
        chk({tag, " lv"}, 32'(load_valid_out), 1);
        chk({tag, " done stall"}, 32'(stall), 0);
        chk({tag, " mis"}, 32'(misalign_err), 0);
        mem_access_in = 1'b0;
        tick();
        chk({tag, " lv drop"}, 32'(load_valid_out), 0);
        chk({tag, " hold"}, load_data_out, ed);
    endtask
    initial begin
        bus.ready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = 32'h0;
        tick();
        tick();
        chk("rst req", 32'(bus.req), 0);
        chk("rst we", 32'(bus.we), 0);
        chk("rst be", 32'(bus.be), 0);
        chk("rst addr", bus.addr, 0);
        chk("rst wdata", bus.wdata, 0);
        chk("rst ld", load_data_out, 0);
        chk("rst lv", 32'(load_valid_out), 0);
        chk("rst mis", 32'(misalign_err), 0);
        chk("rst stall", 32'(stall), 0);
        rst = 1'b0;
        tick();
        do_store(32'h100, SZ_WORD, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h100, 1, "st_w");
        do_load(32'h203, SZ_BYTE, 1'b1, 32'h123456F0, 2, 4'b0001, 32'h200, 32'hFFFFFFF0, "ld_bs");
        do_load(32'h202, SZ_HALF, 1'b0, 32'hAAAA8001, 1, 4'b0011, 32'h200, 32'h00008001, "ld_hu");
        do_load(32'h202, SZ_HALF, 1'b1, 32'hAAAA8001, 1, 4'b0011, 32'h200, 32'hFFFF8001, "ld_hs");
        do_load(32'h200, SZ_BYTE, 1'b0, 32'h80FF0000, 1, 4'b1000, 32'h200, 32'h00000080, "ld_bu");
        do_load(32'h104, SZ_WORD, 1'b1, 32'h80000001, 3, 4'b1111, 32'h104, 32'h80000001, "ld_w");
        do_store(32'h11, SZ_BYTE, 32'h000000A5, 4'b0100, 32'hA5A5A5A5, 32'h10, 5, "st_b");
        do_store(32'h2, SZ_HALF, 32'h1234ABCD, 4'b0011, 32'hABCDABCD, 32'h0, 0, "st_h");
        mem_access_in = 1'b1;
        addr_in = 32'h300;
        access_size_in = SZ_WORD;
        rw_in = 1'b0;
        tick();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        chk("rstw stall", 32'(stall), 1);
        rst = 1'b1;
        mem_access_in = 1'b0;
        tick();
        chk("rstw req", 32'(bus.req), 0);
        chk("rstw stall", 32'(stall), 0);
        chk("rstw lv", 32'(load_valid_out), 0);
        rst = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h5555AAAA;
        tick();
        bus.rvalid = 1'b0;
        chk("late rvalid lv", 32'(load_valid_out), 0);
        chk("late rvalid ld", load_data_out, 0);
        chk("late rvalid stall", 32'(stall), 0);
        tick();
        chk("late rvalid lv2", 32'(load_valid_out), 0);
        chk("late rvalid req", 32'(bus.req), 0);
`ifdef MISALIGN_TRAP_EN
        mem_access_in = 1'b1;
        addr_in = 32'h102;
        access_size_in = SZ_WORD;
        rw_in = 1'b0;
        #1 chk("mis idle stall", 32'(stall), 1);
        tick();
        chk("mis req", 32'(bus.req), 0);
        chk("mis err", 32'(misalign_err), 1);
        chk("mis lv", 32'(load_valid_out), 0);
        chk("mis stall", 32'(stall), 0);
        mem_access_in = 1'b0;
        tick();
        chk("mis err drop", 32'(misalign_err), 0);
        chk("mis req2", 32'(bus.req), 0);
`else
        do_load(32'h102, SZ_WORD, 1'b0, 32'hCAFEF00D, 1, 4'b1111, 32'h100, 32'hCAFEF00D, "ld_mis");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
